// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: funct3 encodings,
// FSM state encoding, iteration count and a conditional negate helper.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negate when n is set.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration. prem is the 33-bit shifted partial
// remainder ({rem, next dividend bit}); the quotient bit is set when the
// divisor fits, in which case the subtracted value becomes the new remainder.
// Since the incoming remainder is always below the divisor, the result
// always fits in 32 bits.
module div_step (
    input  logic [32:0] prem,
    input  logic [31:0] divisor,
    output logic [31:0] prem_next,
    output logic        q_bit
);

    // Compare-and-subtract; the 32-bit wrap is exact whenever q_bit is set.
    always_comb begin
        q_bit     = prem[32] | (prem[31:0] >= divisor);
        prem_next = q_bit ? (prem[31:0] - divisor) : prem[31:0];
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iteration and finish one cycle after the start is accepted.
module div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);

    state_t state, nxt;

    logic [31:0]      dvd;       // dividend magnitude, shifted out MSB-first, quotient shifted in
    logic [31:0]      dsr;       // divisor magnitude
    logic [31:0]      prem;      // partial remainder
    logic [CNT_W-1:0] cnt;
    logic             is_rem;
    logic             neg_quo;
    logic             neg_rem;
    logic             spec;      // divide-by-zero or signed overflow
    logic [31:0]      spec_res;

    // Operand decode at the request boundary
    logic        in_signed, a_neg, b_neg, in_div0, in_ovf, in_special;
    logic [31:0] in_spec_res;
    logic        last;

    logic [32:0] shifted;
    logic [31:0] prem_next;
    logic        q_bit;
    logic [31:0] fin_res;

    // Sign handling and special-case detection for incoming operands
    always_comb begin
        in_signed   = (funct3 == OP_DIV) || (funct3 == OP_REM);
        a_neg       = in_signed & a[31];
        b_neg       = in_signed & b[31];
        in_div0     = (b == 32'd0);
        in_ovf      = in_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        in_special  = in_div0 | in_ovf;
        if (in_div0)
            in_spec_res = funct3[1] ? a : 32'hFFFF_FFFF;
        else
            in_spec_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    div_step u_step (
        .prem      (shifted),
        .divisor   (dsr),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // Iteration datapath and final sign fix-up
    always_comb begin
        shifted = {prem, dvd[31]};
        last    = (cnt == CNT_W'(ITERS - 1));
        fin_res = is_rem ? cond_neg(prem_next, neg_rem)
                         : cond_neg({dvd[30:0], q_bit}, neg_quo);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // Next-state logic; flush overrides everything but reset
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef DIV_EARLY_OUT_EN
                nxt = in_special ? S_DONE : S_CALC;
`else
                nxt = S_CALC;
`endif
            end
            S_CALC: if (last) nxt = S_DONE;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (flush) nxt = S_IDLE;
    end

    // Status outputs decoded from state; done is unaffected by a same-cycle flush
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Operand capture, iteration and result register; flush freezes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd      <= '0;
            dsr      <= '0;
            prem     <= '0;
            cnt      <= '0;
            is_rem   <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            spec     <= 1'b0;
            spec_res <= '0;
            y        <= '0;
        end else if (!flush) begin
            if (state == S_IDLE && start) begin
                dvd      <= cond_neg(a, a_neg);
                dsr      <= cond_neg(b, b_neg);
                prem     <= '0;
                cnt      <= '0;
                is_rem   <= funct3[1];
                neg_quo  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                spec     <= in_special;
                spec_res <= in_spec_res;
`ifdef DIV_EARLY_OUT_EN
                if (in_special) y <= in_spec_res;
`endif
            end else if (state == S_CALC) begin
                dvd  <= {dvd[30:0], q_bit};
                prem <= prem_next;
                cnt  <= cnt + 1'b1;
                if (last) y <= spec ? spec_res : fin_res;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed spec vectors, randomized ops
// against an arithmetic reference, flush/reset/ignored-start scenarios.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [31:0] a, b;
    logic [1:0]  funct3;
    logic        busy, done;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .a(a), .b(b), .funct3(funct3),
        .busy(busy), .done(done), .y(y)
    );

    // Reference result from the arithmetic rules of each op
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] d);
        logic rem_op, sgn;
        rem_op = f[1];
        sgn    = !f[0];
        if (d == 32'd0) return rem_op ? x : 32'hFFFF_FFFF;
        if (sgn) begin
            if (x == 32'h8000_0000 && d == 32'hFFFF_FFFF) return rem_op ? 32'd0 : 32'h8000_0000;
            return rem_op ? 32'($signed(x) % $signed(d)) : 32'($signed(x) / $signed(d));
        end
        return rem_op ? (x % d) : (x / d);
    endfunction

    function automatic int lat_model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] d);
`ifdef DIV_EARLY_OUT_EN
        if (d == 32'd0 || (!f[0] && x == 32'h8000_0000 && d == 32'hFFFF_FFFF)) return 1;
`endif
        return 33;
    endfunction

    // Issue one op from IDLE; report latency (cycles after the accept cycle),
    // result, and the done/y seen one cycle after done.
    task automatic run_op(input logic [1:0] f, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output logic [31:0] res,
                          output logic done_after, output logic [31:0] y_after);
        funct3 = f; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 99; res = 32'hDEAD_BEEF; done_after = 1'b1; y_after = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k; res = y;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 99) begin
            @(posedge clk); #1;
            done_after = done;
            y_after    = y;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; flush = 1'b0; a = '0; b = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b y=%h required 0/0/0", busy, done, y);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    typedef struct {
        logic [1:0]  f;
        logic [31:0] x;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed;
        vec_t v[8];
        int lat; logic [31:0] res, ya; logic da;
        v[0] = '{2'b01, 32'd100,        32'd7,          32'd14};
        v[1] = '{2'b11, 32'd100,        32'd7,          32'd2};
        v[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        v[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        v[4] = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
        v[5] = '{2'b11, 32'd5,          32'd0,          32'd5};
        v[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        v[7] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].f, v[i].x, v[i].d, lat, res, da, ya);
            checks++;
            if (lat != lat_model(v[i].f, v[i].x, v[i].d) || res !== v[i].exp) begin
                errors++;
                $display("FAIL directed_%0d lat=%0d y=%h required lat=%0d y=%h",
                         i, lat, res, lat_model(v[i].f, v[i].x, v[i].d), v[i].exp);
            end
            checks++;
            if (da !== 1'b0 || ya !== v[i].exp) begin
                errors++;
                $display("FAIL hold_%0d done=%b y=%h required done=0 y=%h", i, da, ya, v[i].exp);
            end
        end
    endtask

    task automatic test_random;
        int lat; logic [31:0] res, ya, x, d, exp; logic da; logic [1:0] f;
        for (int i = 0; i < 30; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: d = 32'd0;
                1: d = 32'hFFFF_FFFF;
                2: d = 32'($urandom_range(1, 20));
                default: d = $urandom;
            endcase
            x = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            exp = model(f, x, d);
            run_op(f, x, d, lat, res, da, ya);
            checks++;
            if (lat != lat_model(f, x, d) || res !== exp || da !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h lat=%0d y=%h required lat=%0d y=%h",
                         i, f, x, d, lat, res, lat_model(f, x, d), exp);
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] prev, res, ya; logic seen, da; int lat;
        prev = y; seen = 1'b0;
        funct3 = 2'b01; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;                    // cycle T+1
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;                          // cycle T+10
        if (done) seen = 1'b1;
        @(posedge clk); #1;                    // cycle T+11
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || seen || y !== prev) begin
            errors++;
            $display("FAIL flush_kill busy=%b done=%b seen=%b y=%h required 0/0/0 y=%h",
                     busy, done, seen, y, prev);
        end
        run_op(2'b01, 32'd77, 32'd5, lat, res, da, ya);
        checks++;
        if (lat != 33 || res !== 32'd15) begin
            errors++;
            $display("FAIL flush_restart lat=%0d y=%h required lat=33 y=0000000f", lat, res);
        end
        // flush beats a simultaneous start in IDLE
        start = 1'b1; flush = 1'b1; funct3 = 2'b01; a = 32'd9; b = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_start busy=%b required 0", busy);
        end
    endtask

    task automatic test_flush_done;
        logic ok;
        ok = 1'b0;
        funct3 = 2'b11; a = 32'd50; b = 32'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 33; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;                          // cycle T+33, the done cycle
        #1;
        ok = (done === 1'b1) && (y === 32'd2);
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_done ok=%b busy=%b required ok=1 busy=0", ok, busy);
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] res, ya; logic da;
        funct3 = 2'b00; a = 32'd12345; b = 32'd11; start = 1'b1;
        @(posedge clk); #1;                    // cycle T+1
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; start = 1'b1; flush = 1'b1;   // cycle T+5
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b y=%h required 0/0/0", busy, done, y);
        end
        while (busy === 1'b0 && $time < 2_000_000) begin   // idle up to T+16
            repeat (10) @(posedge clk);
            #1;
            break;
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle busy=%b done=%b required 0/0", busy, done);
        end
        run_op(2'b00, 32'd12345, 32'd11, lat, res, da, ya);
        checks++;
        if (lat != 33 || res !== 32'd1122) begin
            errors++;
            $display("FAIL reset_restart lat=%0d y=%h required lat=33 y=%h", lat, res, 32'd1122);
        end
    endtask

    task automatic test_start_ignored;
        int lat; logic [31:0] res;
        lat = 99; res = 32'hDEAD_BEEF;
        funct3 = 2'b01; a = 32'd1000; b = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start = 1'b1; funct3 = 2'b11; a = 32'd7; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k; res = y;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lat != 33 || res !== 32'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_calc lat=%0d y=%h busy=%b required lat=33 y=%h busy=0",
                     lat, res, busy, 32'd100);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_flush;
        test_flush_done;
        test_reset_mid;
        test_start_ignored;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 flush  input  1  abort the in-flight operation (pipeline kill).
REQ-006 a  input  32  dividend; captured on an accepted start.
REQ-007 b  input  32  divisor; captured on an accepted start.
REQ-008 funct3  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; captured on an accepted start.
REQ-009 busy  output  1  high while not IDLE.
REQ-010 done  output  1  one-cycle pulse; y is valid in that cycle.
REQ-011 y  output  32  result; holds its last value until the next done.

Function
REQ-012 SHALL accept start only in IDLE with flush low; start in any other state SHALL be ignored.
REQ-013 SHALL implement states IDLE, CALC and DONE; transitions are IDLE->CALC on an accepted start, CALC->DONE after 32 iterations, and DONE->IDLE unconditionally.
REQ-014 SHALL perform a radix-2 restoring division on 32-bit magnitudes, one quotient bit per CALC cycle, using a 33-bit partial remainder.
REQ-015 Signed ops (DIV, REM) SHALL take magnitudes of a and b at capture; the quotient is negated iff sign(a)!=sign(b); the remainder takes the sign of a.
REQ-016 Unsigned ops SHALL use a and b unmodified.
REQ-017 Divide by zero SHALL give quotient 0xFFFFFFFF (DIV, DIVU) and remainder = a (REM, REMU).
REQ-018 Signed overflow (a=0x80000000, b=0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0.
REQ-019 For a start accepted at cycle T, done SHALL be high only at T+33, with y registered in that same cycle (full-latency path).
REQ-020 y SHALL be the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-021 flush in any state SHALL return the block to IDLE on the next edge with no done pulse and y unchanged; flush SHALL win over a simultaneous start.
REQ-022 flush in the DONE cycle SHALL NOT suppress that cycle's done.

Reset
REQ-023 reset SHALL force IDLE, busy=0, done=0, y=0 and clear all datapath registers, including when asserted mid-operation.
REQ-024 reset SHALL take priority over start and flush.

Configuration
REQ-025 Macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and signed overflow SHALL go IDLE->DONE directly, with done at T+1.
REQ-026 Without DIV_EARLY_OUT_EN, every operation SHALL use the 33-cycle path.
REQ-027 Result values SHALL be identical with and without the macro; only latency differs.

Structure
REQ-028 Package div_pkg SHALL hold the funct3 encodings (DIV, DIVU, REM, REMU), the state enum and the iteration count constant (32).
REQ-029 A combinational sub-module div_step SHALL compute one restoring iteration: partial remainder and divisor in, next partial remainder and quotient bit out.

Verification
REQ-030 DIVU a=100, b=7 -> done at T+33, y=14; REMU on the same operands -> y=2.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> y=0xFFFFFFFD (-3); REM on the same operands -> y=0xFFFFFFFF (-1).
REQ-032 DIV a=5, b=0 -> y=0xFFFFFFFF; REMU a=5, b=0 -> y=5; done at T+1 with DIV_EARLY_OUT_EN and at T+33 without.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> y=0x80000000; REM on the same operands -> y=0.
REQ-034 Start DIVU, assert flush at T+10 -> busy=0 at T+11, no done pulse, y holds its previous value; a new start at T+11 is accepted.
REQ-035 Assert reset at T+5 of an operation -> at the next edge busy=0, done=0, y=0; a start at T+16 while busy is not possible, and a start during CALC is ignored.
